// File: rtl/sbox_pipe.sv
// sbox_pipe: three-stage AES SubBytes / InvSubBytes over LANES byte lanes.
// GF(2^8) inversion uses the tower GF(((2^2)^2)^2) with phi = 2 and lambda = 0xC.
module sbox_pipe #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data
);
  localparam int DW = 8 * LANES;
  localparam int NW = 4 * LANES;
  localparam logic [3:0] LAMBDA = 4'hC;

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic hh;
    hh = a[1] & b[1];
    return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] gf4_phi(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = gf4_mul(a[3:2], b[3:2]);
    return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
            gf4_phi(hh) ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    logic [1:0] hs;
    hs = gf4_sq(a[3:2]);
    return {hs, gf4_phi(hs) ^ gf4_sq(a[1:0])};
  endfunction

  // In GF(4) every nonzero a has a^3 = 1, so squaring is inversion (and 0 stays 0).
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] dn;
    logic [1:0] di;
    dn = gf4_phi(gf4_sq(a[3:2])) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
    di = gf4_sq(dn);
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction

  function automatic logic [7:0] map_iso(input logic [7:0] q);
    logic [7:0] x;
    x[7] = q[7] ^ q[5];
    x[6] = q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    x[5] = q[7] ^ q[5] ^ q[3] ^ q[2];
    x[4] = q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1];
    x[3] = q[7] ^ q[6] ^ q[2] ^ q[1];
    x[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    x[1] = q[6] ^ q[4] ^ q[1];
    x[0] = q[6] ^ q[1] ^ q[0];
    return x;
  endfunction

  function automatic logic [7:0] map_inv(input logic [7:0] q);
    logic [7:0] x;
    x[7] = q[7] ^ q[6] ^ q[5] ^ q[1];
    x[6] = q[6] ^ q[2];
    x[5] = q[6] ^ q[5] ^ q[1];
    x[4] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1];
    x[3] = q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    x[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    x[1] = q[5] ^ q[4];
    x[0] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0];
    return x;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  logic          w_en;
  logic [NW-1:0] w_ah1, w_al1, w_d1, w_dinv2;
  logic [DW-1:0] w_res3;
  logic          r_v1, r_v2, r_v3, r1_inv, r2_inv;
  logic [NW-1:0] r1_ah, r1_al, r1_d, r2_ah, r2_al, r2_dinv;
  logic [DW-1:0] r_out;

  assign w_en      = !r_v3 | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign out_data  = r_out;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] w_x, w_m, w_y;
    logic [3:0] w_h, w_l;
    assign w_x = in_inv ? aff_inv(in_data[8*k +: 8]) : in_data[8*k +: 8];
    assign w_m = map_iso(w_x);
    assign w_ah1[4*k +: 4] = w_m[7:4];
    assign w_al1[4*k +: 4] = w_m[3:0];
    assign w_d1[4*k +: 4]  = gf16_mul(LAMBDA, gf16_sq(w_m[7:4])) ^
                             gf16_mul(w_m[7:4], w_m[3:0]) ^ gf16_sq(w_m[3:0]);
    assign w_dinv2[4*k +: 4] = gf16_inv(r1_d[4*k +: 4]);
    assign w_h = gf16_mul(r2_ah[4*k +: 4], r2_dinv[4*k +: 4]);
    assign w_l = gf16_mul(r2_ah[4*k +: 4] ^ r2_al[4*k +: 4], r2_dinv[4*k +: 4]);
    assign w_y = map_inv({w_h, w_l});
    assign w_res3[8*k +: 8] = r2_inv ? w_y : aff_fwd(w_y);
  end

  // Stage 1: mapped halves and norm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r1_inv <= 1'b0;
      r1_ah  <= {NW{1'b0}};
      r1_al  <= {NW{1'b0}};
      r1_d   <= {NW{1'b0}};
    end else if (w_en) begin
      r_v1   <= in_valid;
      r1_inv <= in_inv;
      r1_ah  <= w_ah1;
      r1_al  <= w_al1;
      r1_d   <= w_d1;
    end
  end

  // Stage 2: norm inverse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r2_inv  <= 1'b0;
      r2_ah   <= {NW{1'b0}};
      r2_al   <= {NW{1'b0}};
      r2_dinv <= {NW{1'b0}};
    end else if (w_en) begin
      r_v2    <= r_v1;
      r2_inv  <= r1_inv;
      r2_ah   <= r1_ah;
      r2_al   <= r1_al;
      r2_dinv <= w_dinv2;
    end
  end

  // Stage 3: output register, zeroed when no valid word arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3  <= 1'b0;
      r_out <= {DW{1'b0}};
    end else if (w_en) begin
      r_v3  <= r_v2;
      r_out <= r_v2 ? w_res3 : {DW{1'b0}};
    end
  end
endmodule

// File: tb/tb_sbox_pipe.sv
// Self-checking bench for sbox_pipe: field-arithmetic S-box model, scoreboard with
// advance-counted latency, and directed vectors with literal expectations.
module tb_sbox_pipe;
  localparam int LANES = 4;
  localparam int DW = 8 * LANES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int adv_cnt = 0;
  int cyc = 0;
  int lat;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } ent_t;
  ent_t q[$];

  sbox_pipe #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = inv ? isb[d[8*k +: 8]] : sb[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [DW-1:0] bp_word(input int i);
    return 32'h11223344 + 32'(i) * 32'h01010101;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input logic [DW-1:0] d, input logic inv);
    logic ok;
    int n;
    in_valid = 1'b1;
    in_data = d;
    in_inv = inv;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) timeout("send_accept");
  endtask

  task automatic wait_out(input logic [DW-1:0] exp, input string nm, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!out_valid && l < 30);
    if (!out_valid) timeout(nm);
    else chk(nm, out_data, exp);
  endtask

  // Scoreboard: a word accepted on advancing edge A is visible after advancing edge A+2.
  always @(negedge clk) begin : mon
    logic exp_v;
    if (rst) begin
      q.delete();
    end else begin
      exp_v = (q.size() > 0) && (adv_cnt == q[0].acc + 2);
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_v});
      if (out_valid && exp_v) chk("out_data", out_data, q[0].data);
      else if (!out_valid) chk("out_zero", out_data, 32'h0);
      if (out_valid && out_ready && exp_v) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{exp_word(in_data, in_inv), adv_cnt + 1});
      if (in_ready) adv_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [DW-1:0] w;
    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      for (int e = 0; e < 254; e++) r = gmul(r, 8'(x));
      sb[x] = affine(r);
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    chk("pin_sb00", {24'h0, sb[0]}, 32'h63);
    chk("pin_sb01", {24'h0, sb[1]}, 32'h7C);
    chk("pin_sb53", {24'h0, sb[8'h53]}, 32'hED);
    chk("pin_sbFF", {24'h0, sb[8'hFF]}, 32'h16);
    chk("pin_isb63", {24'h0, isb[8'h63]}, 32'h00);
    chk("pin_isb00", {24'h0, isb[0]}, 32'h52);

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    send(32'h000153FF, 1'b0); in_valid = 1'b0;
    wait_out(32'h637CED16, "fwd_word", lat);
    chk("fwd_latency", 32'(lat), 32'd3);
    @(negedge clk);
    chk("fwd_one_wide", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;

    send(32'h637CED16, 1'b1); in_valid = 1'b0;
    wait_out(32'h000153FF, "inv_word", lat);
    chk("inv_latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    send(32'h0, 1'b0); send(32'h0, 1'b1); send(32'h0, 1'b0); in_valid = 1'b0;
    wait_out(32'h63636363, "alt0", lat);
    @(negedge clk); chk("alt1", out_data, 32'h52525252);
    @(negedge clk); chk("alt2", out_data, 32'h63636363);
    @(posedge clk); #1;

    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 256; v++) begin
        for (int k = 0; k < LANES; k++) w[8*k +: 8] = 8'(v + 64 * k);
        send(w, m[0]);
      end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_word(i), i[0]);
        in_valid = 1'b0;
      end
      begin
        int cnt, t0, t1, wt;
        wt = 0;
        do begin
          @(negedge clk);
          wt++;
        end while (!out_valid && wt < 30);
        if (!out_valid) timeout("bp_first");
        t0 = cyc;
        cnt = 1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
          chk("stall_hold", out_data, exp_word(bp_word(1), 1'b1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wt = 0;
        while (cnt < 8 && wt < 40) begin
          @(negedge clk);
          wt++;
          if (out_valid && out_ready) cnt++;
        end
        t1 = cyc;
        chk("bp_count", 32'(cnt), 32'd8);
        chk("bp_span", 32'(t1 - t0), 32'd12);
      end
    join
    repeat (4) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(32'h01010101, 1'b0); in_valid = 1'b0;
    wait_out(32'h7C7C7C7C, "hold_word", lat);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_data", out_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    send(32'hA1B2C3D4, 1'b0); send(32'h55667788, 1'b1); send(32'h99AABBCC, 1'b0);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_quiet", {31'h0, out_valid}, 32'h0);
    end
    @(posedge clk); #1;
    send(32'h01010101, 1'b0); in_valid = 1'b0;
    wait_out(32'h7C7C7C7C, "fresh_word", lat);
    chk("fresh_latency", 32'(lat), 32'd3);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
